// File: rtl/mem_access_unit.sv
// Data-memory access stage: issues one aligned request per load/store, waits for
// dmem_ready with a bounded timeout, and returns the lane-extracted load result.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_alu_y,
    input  logic [31:0] m_wdata,
    input  logic        m_mem_read,
    input  logic        m_mem_write,
    input  logic [2:0]  m_funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] m_rdata,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Counter value at which the final waiting BUSY cycle times out.
    localparam logic [7:0] CntLimit = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_error_q, bus_error_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        write_q, write_d;

    logic        request;
    logic        access;
    logic        is_half;
    logic        is_word;
    logic        bad_funct3;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Request decode and alignment check
    always_comb begin
        request    = m_mem_read | m_mem_write;
        is_half    = (m_funct3[1:0] == 2'b01);
        is_word    = (m_funct3 == 3'b010);
        bad_funct3 = (m_funct3 == 3'b011) || (m_funct3 == 3'b110) || (m_funct3 == 3'b111);
        misaligned = request & ((is_half & m_alu_y[0]) |
                                (is_word & (m_alu_y[1:0] != 2'b00)) |
                                bad_funct3);
        access     = request & ~misaligned;
    end

    // Store lane placement; loads reuse the byte enables with zero write data
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = m_wdata;
        case (m_funct3[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << m_alu_y[1:0];
                lane_wdata = {4{m_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << {m_alu_y[1], 1'b0};
                lane_wdata = {2{m_wdata[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = m_wdata;
            end
        endcase
        if (!m_mem_write) begin
            lane_wdata = 32'h0;
        end
    end

    // Load extraction uses the offset and size captured at issue time
    always_comb begin
        case (addr_lo_q)
            2'b00:   ld_byte = dmem_rdata[7:0];
            2'b01:   ld_byte = dmem_rdata[15:8];
            2'b10:   ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rdata_d     = rdata_q;
        bus_error_d = 1'b0;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        write_d     = write_q;

        case (state_q)
            StIdle: begin
                if (access) begin
                    state_d   = StBusy;
                    cnt_d     = 8'h0;
                    req_d     = 1'b1;
                    we_d      = m_mem_write;
                    addr_d    = {m_alu_y[31:2], 2'b00};
                    wdata_d   = lane_wdata;
                    be_d      = lane_be;
                    addr_lo_d = m_alu_y[1:0];
                    funct3_d  = m_funct3;
                    write_d   = m_mem_write;
                end
            end
            StBusy: begin
                // A ready response takes priority over a coincident timeout
                if (dmem_ready) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = write_q ? 32'h0 : ld_ext;
                end else if (cnt_q == CntLimit) begin
                    state_d     = StDone;
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    rdata_d     = 32'h0;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'h0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rdata_q     <= 32'h0;
            bus_error_q <= 1'b0;
            addr_lo_q   <= 2'b00;
            funct3_q    <= 3'b000;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rdata_q     <= rdata_d;
            bus_error_q <= bus_error_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            write_q     <= write_d;
        end
    end

    always_comb begin
        stall      = ((state_q == StIdle) & access) | (state_q == StBusy);
        dmem_req   = req_q;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_wdata = wdata_q;
        dmem_be    = be_q;
        m_rdata    = rdata_q;
        bus_error  = bus_error_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of load/store vectors with a response-latency model,
// a scoreboard of expected load results, and hand sequences for timeout and reset abort.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m_alu_y;
    logic [31:0] m_wdata;
    logic        m_mem_read;
    logic        m_mem_write;
    logic [2:0]  m_funct3;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] m_rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_error;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .m_alu_y    (m_alu_y),
        .m_wdata    (m_wdata),
        .m_mem_read (m_mem_read),
        .m_mem_write(m_mem_write),
        .m_funct3   (m_funct3),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .m_rdata    (m_rdata),
        .stall      (stall),
        .misaligned (misaligned),
        .bus_error  (bus_error)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned wait_n;
        logic        exp_mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_we;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rdata = 32'h0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int unsigned wait_n,
                                input logic mis, input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ewd, input logic ewe,
                                input logic [31:0] erd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.wait_n = wait_n; v.exp_mis = mis; v.exp_addr = ea; v.exp_be = ebe;
        v.exp_wdata = ewd; v.exp_we = ewe; v.exp_rdata = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m_mem_read  = 1'b0;
        m_mem_write = 1'b0;
        m_funct3    = 3'b000;
        m_alu_y     = 32'h0;
        m_wdata     = 32'h0;
        dmem_ready  = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got 0x%08h expected none (scoreboard empty)", name, m_rdata);
        end else begin
            exp = sb_q.pop_front();
            check(name, m_rdata, exp);
            last_rdata = exp;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v);
        int  busy;
        int  stall_n;
        bit  done;
        bit  rdy;
        m_mem_read  = v.rd;
        m_mem_write = v.wr;
        m_funct3    = v.f3;
        m_alu_y     = v.addr;
        m_wdata     = v.wdata;
        dmem_rdata  = v.rdata;
        dmem_ready  = 1'b0;
        #1;
        check("misaligned", 32'(misaligned), 32'(v.exp_mis));
        if (v.exp_mis) begin
            check("mis_stall", 32'(stall), 32'h0);
            @(negedge clk);
            check("mis_req", 32'(dmem_req), 32'h0);
            check("mis_stall_next", 32'(stall), 32'h0);
            idle_inputs();
            return;
        end
        sb_q.push_back(v.exp_rdata);
        stall_n = stall ? 1 : 0;
        @(negedge clk);
        check("req", 32'(dmem_req), 32'h1);
        check("we", 32'(dmem_we), 32'(v.exp_we));
        check("be", 32'(dmem_be), 32'(v.exp_be));
        check("wdata", dmem_wdata, v.exp_wdata);
        busy = 0;
        done = 1'b0;
        while (!done && busy < 16) begin
            busy++;
            stall_n += stall ? 1 : 0;
            check("addr_held", dmem_addr, v.exp_addr);
            rdy = (busy == int'(v.wait_n) + 1);
            dmem_ready = rdy;
            @(negedge clk);
            dmem_ready = 1'b0;
            done = rdy;
        end
        check("busy_cycles", 32'(busy), 32'(v.wait_n + 1));
        check("done_stall", 32'(stall), 32'h0);
        check("done_req", 32'(dmem_req), 32'h0);
        check("done_we", 32'(dmem_we), 32'h0);
        check("done_bus_error", 32'(bus_error), 32'h0);
        check("stall_cycles", 32'(stall_n), 32'(v.wait_n + 2));
        pop_check("m_rdata");
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy;
        vecs.push_back(mk(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 1,
                          0, 32'h0000_1000, 4'b1000, 32'h0, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0,
                          0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 1, 32'h0));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0,
                          1, 32'h0, 4'h0, 32'h0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b000, 32'h0000_4001, 32'h1234_56EF, 32'h0, 2,
                          0, 32'h0000_4000, 4'b0010, 32'hEFEF_EFEF, 1, 32'h0));
        vecs.push_back(mk(0, 1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0, 0,
                          0, 32'h0000_5000, 4'b1111, 32'hDEAD_BEEF, 1, 32'h0));
        vecs.push_back(mk(1, 0, 3'b100, 32'h0000_6002, 32'h0, 32'h11AB_2233, 0,
                          0, 32'h0000_6000, 4'b0100, 32'h0, 0, 32'h0000_00AB));
        // Ready arrives in the same cycle the wait counter would time out
        vecs.push_back(mk(1, 0, 3'b001, 32'h0000_7002, 32'h0, 32'h9876_1234, 3,
                          0, 32'h0000_7000, 4'b1100, 32'h0, 0, 32'hFFFF_9876));
        vecs.push_back(mk(1, 0, 3'b101, 32'h0000_7000, 32'h0, 32'h1234_8765, 0,
                          0, 32'h0000_7000, 4'b0011, 32'h0, 0, 32'h0000_8765));
        vecs.push_back(mk(1, 0, 3'b010, 32'h0000_8000, 32'h0, 32'hCAFE_F00D, 1,
                          0, 32'h0000_8000, 4'b1111, 32'h0, 0, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 1, 3'b001, 32'h0000_9001, 32'h0, 32'h0, 0,
                          1, 32'h0, 4'h0, 32'h0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 3'b011, 32'h0000_A000, 32'h0, 32'h0, 0,
                          1, 32'h0, 4'h0, 32'h0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 3'b110, 32'h0000_A004, 32'h0, 32'h0, 0,
                          1, 32'h0, 4'h0, 32'h0, 0, 32'h0));
        // Store wins over a simultaneous load
        vecs.push_back(mk(1, 1, 3'b010, 32'h0000_B004, 32'h0102_0304, 32'h5555_5555, 0,
                          0, 32'h0000_B004, 4'b1111, 32'h0102_0304, 1, 32'h0));
        vecs.push_back(mk(1, 0, 3'b000, 32'h0000_C000, 32'h0, 32'h0000_007F, 0,
                          0, 32'h0000_C000, 4'b0001, 32'h0, 0, 32'h0000_007F));

        reset      = 1'b0;
        dmem_rdata = 32'h0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_we", 32'(dmem_we), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_bus_error", 32'(bus_error), 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Ready while idle must not disturb anything
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("idle_ready_rdata", m_rdata, last_rdata);
        check("idle_ready_req", 32'(dmem_req), 32'h0);
        check("idle_ready_stall", 32'(stall), 32'h0);

        // Reset mid-BUSY aborts the request asynchronously
        m_mem_read = 1'b1;
        m_funct3   = 3'b010;
        m_alu_y    = 32'h0000_0020;
        @(negedge clk);
        check("pre_abort_req", 32'(dmem_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("abort_req", 32'(dmem_req), 32'h0);
        check("abort_addr", dmem_addr, 32'h0);
        check("abort_m_rdata", m_rdata, 32'h0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        run_vec(mk(1, 0, 3'b101, 32'h0000_0010, 32'h0, 32'h1234_8765, 0,
                   0, 32'h0000_0010, 4'b0011, 32'h0, 0, 32'h0000_8765));

        // Timeout: no ready ever arrives
        m_mem_read = 1'b1;
        m_funct3   = 3'b010;
        m_alu_y    = 32'h0000_0040;
        dmem_ready = 1'b0;
        sb_q.push_back(32'h0);
        #1;
        check("to_issue_stall", 32'(stall), 32'h1);
        busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus_error) break;
            busy++;
            check("to_req_held", 32'(dmem_req), 32'h1);
        end
        check("to_busy_cycles", 32'(busy), 32'h4);
        check("to_bus_error", 32'(bus_error), 32'h1);
        check("to_req_drop", 32'(dmem_req), 32'h0);
        check("to_done_stall", 32'(stall), 32'h0);
        pop_check("to_m_rdata");
        idle_inputs();
        @(negedge clk);
        check("to_pulse_end", 32'(bus_error), 32'h0);
        check("to_idle_stall", 32'(stall), 32'h0);
        check("to_idle_req", 32'(dmem_req), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
